vga_text_renderer: RTL and testbench
====================================

// Module: vga_text_renderer
// PURPOSE
//  Pixel source directly downstream of vga_display: takes its x/y/isDispRGB/hsync/vsync and
//  produces 8-bit RGB (3-3-2) for an 80x30 text screen, 8x16 glyphs. Holds a 2400x8 char
//  buffer (CPU write port, sync-read RAM), fetches glyphs from an external font ROM, draws a
//  blinking cursor, and provides a hardware clear-screen sweep. Syncs delayed to match pixels.
// PARAMETERS
//  FG_COLOR      8'hFF  foreground RGB332
//  BG_COLOR      8'h00  background RGB332
//  BLINK_FRAMES  30     frames per cursor blink half-period (1..255)
// PORTS
//  clk_25mhz  in   1   pixel clock, same clock as vga_display
//  rst_n      in   1   asynchronous active-low reset
//  x          in   10  pixel column from vga_display (valid only when de=1)
//  y          in   10  pixel row from vga_display (valid only when de=1)
//  de         in   1   isDispRGB from vga_display
//  hsync_in   in   1   raw hsync (active low)
//  vsync_in   in   1   raw vsync (active low)
//  wr_en      in   1   char buffer write strobe
//  wr_addr    in   12  cell index row*80+col, 0..2399
//  wr_data    in   8   [6:0] glyph code, [7] inverse video
//  cur_we     in   1   load cursor position
//  cur_addr   in   12  cursor cell index
//  clr_req    in   1   start clear-screen sweep
//  busy       out  1   clear sweep in progress
//  font_addr  out  11  {code[6:0], glyph_row[3:0]} to font ROM
//  font_data  in   8   glyph row, bit7 = leftmost pixel; ROM has exactly 1-cycle read latency
//  rgb        out  8   pixel colour
//  hsync_out  out  1   hsync_in delayed to align with rgb
//  vsync_out  out  1   vsync_in delayed to align with rgb
// BEHAVIOUR
//  Reset: rgb=0, hsync_out=vsync_out=1, cursor=0, blink counter=0, blink phase=on, FSM=CLEAR
//   with sweep pointer 0, busy=1. Buffer contents not reset; the sweep blanks them.
//  Pipeline (3 cycles, fixed): S1 register de/x/y/syncs; RAM addr = y[8:4]*80 + x[9:3]
//   (shift-add, 12 bit), forced to 0 when de=0. S2 RAM data -> font_addr = {code[6:0], y[3:0]};
//   pass x[2:0], inverse bit, cursor-hit flag. S3 font_data returns; bit = font_data[7-x[2:0]].
//  Pixel: on = bit XOR inverse XOR (cursor_hit & phase & glyph_row>=14); rgb = on?FG:BG;
//   rgb=0 whenever delayed de=0. hsync_out/vsync_out = inputs delayed exactly 3 cycles.
//  Cursor: cur_we loads cur_addr (values >=2400 accepted; cursor never shown). Frame tick =
//   vsync_in 1->0 edge; counter counts ticks, at BLINK_FRAMES-1 wraps to 0 and toggles phase.
//  FSM IDLE: wr_en & wr_addr<2400 writes RAM; wr_addr>=2400 dropped. clr_req -> CLEAR,
//   pointer=0, busy=1 next cycle. clr_req and wr_en same cycle: clear wins, write dropped.
//  FSM CLEAR: writes 8'h20 at pointer each cycle, pointer++; write of 2399 -> IDLE, busy=0
//   next cycle (2400 write cycles). wr_en and clr_req ignored while busy. Display reads
//   continue during sweep (partially blank screen allowed).
//  Reset mid-sweep restarts sweep at 0. RAM read/write same cell same cycle: read old data.
// TESTING
//  1 Release rst_n -> busy=1 for 2400 clk, then 0; all cells read back 8'h20; rgb=BG in frame.
//  2 Write cell 0 = 8'h41, font ROM model; x=0..7,y=0 de=1 -> rgb follows glyph row0 bits, 3-clk lag.
//  3 Cell 2399 = 8'hC1 (inverse) at x=632..639,y=464..479 -> FG/BG swapped vs scenario 2 glyph.
//  4 cur_addr=81, 60 vsync falls -> rows 30,31 of cols 8..15 invert on 30 frames, plain 30.
//  5 clr_req during sweep and wr_en to 5 while busy -> sweep unaffected, cell 5 = 8'h20.
//  6 Toggle hsync_in/vsync_in, de=0 -> hsync_out/vsync_out same pattern 3 clk later, rgb=0.

Source files
------------

// File: rtl/vga_text_renderer_if.sv
// vga_text_renderer_if
//   CPU-side port of the text renderer: character buffer writes, cursor
//   load and the clear-screen sweep request/status.
//
//   Handshake: wr_en, cur_we and clr_req are single-cycle strobes sampled on
//   the rising pixel clock. There is no ready signal. Instead, busy=1 means a
//   clear sweep owns the buffer, and any wr_en or clr_req seen while busy is
//   dropped. cur_we is always accepted.
//
//   Signals
//     wr_en    master->slave  character write strobe
//     wr_addr  master->slave  cell index row*80+col
//     wr_data  master->slave  [6:0] glyph code, [7] inverse video
//     cur_we   master->slave  load cursor position
//     cur_addr master->slave  cursor cell index
//     clr_req  master->slave  start clear-screen sweep
//     busy     slave->master  clear sweep in progress
interface vga_text_renderer_if;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic        cur_we;
  logic [11:0] cur_addr;
  logic        clr_req;
  logic        busy;

  modport master (
    output wr_en, wr_addr, wr_data, cur_we, cur_addr, clr_req,
    input  busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, cur_we, cur_addr, clr_req,
    output busy
  );
endinterface

// File: rtl/vga_text_renderer.sv
// vga_text_renderer
//   80x30 text-mode pixel source with 8x16 glyphs. It sits behind vga_display
//   and turns x/y/de into RGB332. The module holds a 2400-cell character
//   buffer. It reads glyph rows from an external font ROM with 1-cycle
//   latency, draws a blinking underline cursor, and runs a hardware sweep
//   that clears the screen.
//
//   Ports
//     clk_25mhz, rst_n      pixel clock, async active-low reset
//     x, y, de              pixel position and display enable
//     hsync_in, vsync_in    raw syncs (active low)
//     cpu                   CPU port (writes, cursor, clear, busy)
//     font_addr, font_data  font ROM address {code, glyph_row} and row data
//     rgb                   pixel colour, 3 clocks behind x/y/de
//     hsync_out, vsync_out  syncs delayed 3 clocks to line up with rgb
//     fsm_state_o           buffer-owner state (0 idle, 1 clearing)
module vga_text_renderer #(
  parameter logic [7:0]  FG_COLOR     = 8'hFF,
  parameter logic [7:0]  BG_COLOR     = 8'h00,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic                clk_25mhz,
  input  logic                rst_n,
  input  logic [9:0]          x,
  input  logic [9:0]          y,
  input  logic                de,
  input  logic                hsync_in,
  input  logic                vsync_in,
  vga_text_renderer_if.slave  cpu,
  output logic [10:0]         font_addr,
  input  logic [7:0]          font_data,
  output logic [7:0]          rgb,
  output logic                hsync_out,
  output logic                vsync_out,
  output logic [0:0]          fsm_state_o
);

  localparam logic [0:0]  ST_IDLE   = 1'b0;
  localparam logic [0:0]  ST_CLEAR  = 1'b1;
  localparam logic [11:0] CELLS     = 12'd2400;
  localparam logic [11:0] LAST_CELL = 12'd2399;
  localparam logic [7:0]  BLINK_TOP = 8'(BLINK_FRAMES - 1);

  // ---------------------------------------------------------------------
  // Buffer owner FSM: clear sweep or CPU writes
  // ---------------------------------------------------------------------
  logic [0:0]  state_q, state_d;
  logic [11:0] ptr_q, ptr_d;
  logic        mem_we;
  logic [11:0] mem_waddr;
  logic [7:0]  mem_wdata;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    mem_we    = 1'b0;
    mem_waddr = cpu.wr_addr;
    mem_wdata = cpu.wr_data;
    case (state_q)
      ST_IDLE: begin
        // A clear request beats a write in the same cycle.
        if (cpu.clr_req) begin
          state_d = ST_CLEAR;
          ptr_d   = 12'd0;
        end else if (cpu.wr_en && (cpu.wr_addr < CELLS)) begin
          mem_we = 1'b1;
        end
      end
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = 8'h20;
        if (ptr_q == LAST_CELL) begin
          state_d = ST_IDLE;
          ptr_d   = 12'd0;
        end else begin
          ptr_d = ptr_q + 12'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      ptr_q   <= 12'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign cpu.busy    = (state_q == ST_CLEAR);
  assign fsm_state_o = state_q;

  // ---------------------------------------------------------------------
  // Cursor position and blink phase
  // ---------------------------------------------------------------------
  logic [11:0] cur_q;
  logic [7:0]  blink_cnt_q;
  logic        phase_q;
  logic        vs_prev_q;
  logic        frame_tick;

  assign frame_tick = vs_prev_q & ~vsync_in;

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      cur_q       <= 12'd0;
      blink_cnt_q <= 8'd0;
      phase_q     <= 1'b1;
      vs_prev_q   <= 1'b1;
    end else begin
      vs_prev_q <= vsync_in;
      if (cpu.cur_we) cur_q <= cpu.cur_addr;
      if (frame_tick) begin
        if (blink_cnt_q == BLINK_TOP) begin
          blink_cnt_q <= 8'd0;
          phase_q     <= ~phase_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + 8'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Character RAM: one write port and one synchronous read port. A read and
  // a write to the same cell in the same cycle returns the old data.
  // ---------------------------------------------------------------------
  logic [7:0]  mem [0:2399];
  logic [7:0]  ram_q;
  logic [11:0] row_w;
  logic [11:0] cell_w;
  logic [11:0] rd_addr;

  // row*80 = row*64 + row*16
  assign row_w   = {7'd0, y[8:4]};
  assign cell_w  = (row_w << 6) + (row_w << 4) + {5'd0, x[9:3]};
  assign rd_addr = de ? cell_w : 12'd0;

  always_ff @(posedge clk_25mhz) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    ram_q <= mem[rd_addr];
  end

  // ---------------------------------------------------------------------
  // Pixel pipeline
  //   S1: RAM read in flight, coordinates and syncs registered
  //   S2: font ROM read in flight
  //   S3: glyph bit selected, rgb registered
  // ---------------------------------------------------------------------
  logic       de1_q, de2_q;
  logic [2:0] xlo1_q, xlo2_q;
  logic [3:0] grow1_q;
  logic       hit1_q, hit2_q;
  logic       inv2_q;
  logic [2:0] hs_q, vs_q;
  logic [7:0] rgb_q;
  logic       glyph_bit;
  logic       pix_on;

  assign font_addr = {ram_q[6:0], grow1_q};

  assign glyph_bit = font_data[3'd7 - xlo2_q];
  assign pix_on    = glyph_bit ^ inv2_q ^ (hit2_q & phase_q);

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      de1_q   <= 1'b0;
      de2_q   <= 1'b0;
      xlo1_q  <= 3'd0;
      xlo2_q  <= 3'd0;
      grow1_q <= 4'd0;
      hit1_q  <= 1'b0;
      hit2_q  <= 1'b0;
      inv2_q  <= 1'b0;
      hs_q    <= 3'b111;
      vs_q    <= 3'b111;
      rgb_q   <= 8'h00;
    end else begin
      // S1. Rows at or beyond 512 are never visible, so y[9] blocks the
      // cursor match there.
      de1_q   <= de;
      xlo1_q  <= x[2:0];
      grow1_q <= y[3:0];
      hit1_q  <= de & ~y[9] & (cell_w == cur_q);
      // S2: the cursor only covers the bottom two glyph rows.
      de2_q   <= de1_q;
      xlo2_q  <= xlo1_q;
      inv2_q  <= ram_q[7];
      hit2_q  <= hit1_q & (grow1_q >= 4'd14);
      // S3
      rgb_q   <= de2_q ? (pix_on ? FG_COLOR : BG_COLOR) : 8'h00;
      hs_q    <= {hs_q[1:0], hsync_in};
      vs_q    <= {vs_q[1:0], vsync_in};
    end
  end

  assign rgb       = rgb_q;
  assign hsync_out = hs_q[2];
  assign vsync_out = vs_q[2];

endmodule

// File: tb/tb_vga_text_renderer.sv
module tb_vga_text_renderer;

  // ---------------------------------------------------------------- clock/reset
  logic clk_25mhz = 1'b0;
  logic rst_n;
  always #20 clk_25mhz = ~clk_25mhz;

  logic [9:0]  x, y;
  logic        de, hsync_in, vsync_in;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic [7:0]  rgb;
  logic        hsync_out, vsync_out;
  logic [0:0]  fsm_state;

  vga_text_renderer_if cpu_if ();

  vga_text_renderer dut (
    .clk_25mhz  (clk_25mhz),
    .rst_n      (rst_n),
    .x          (x),
    .y          (y),
    .de         (de),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .cpu        (cpu_if),
    .font_addr  (font_addr),
    .font_data  (font_data),
    .rgb        (rgb),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .fsm_state_o(fsm_state)
  );

  // Font ROM contents: space is blank, every other code gets a mixed pattern.
  function automatic logic [7:0] font_fn(input logic [6:0] code, input logic [3:0] row);
    logic [7:0] c8;
    logic [7:0] r8;
    c8 = {1'b0, code};
    r8 = {4'd0, row};
    if (code == 7'h20) return 8'h00;
    return (c8 * 8'd37) ^ (r8 * 8'd29) ^ 8'h5A;
  endfunction

  // One-cycle-latency font ROM
  always @(posedge clk_25mhz) font_data <= font_fn(font_addr[10:4], font_addr[3:0]);

  // ---------------------------------------------------------------- scoreboard
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];
  logic [1:0] sync_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected pixel from the cell value, position and cursor visibility.
  function automatic logic [7:0] exp_pix(input logic [7:0] cv, input logic [9:0] px,
                                         input logic [9:0] py, input bit cur_vis);
    logic [7:0] g;
    logic       on;
    g  = font_fn(cv[6:0], py[3:0]);
    on = g[3'd7 - px[2:0]] ^ cv[7] ^ (cur_vis & (py[3:0] >= 4'd14));
    return on ? 8'hFF : 8'h00;
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic cpu_write(input logic [11:0] a, input logic [7:0] d);
    cpu_if.wr_en   = 1'b1;
    cpu_if.wr_addr = a;
    cpu_if.wr_data = d;
    @(posedge clk_25mhz); #1;
    cpu_if.wr_en = 1'b0;
  endtask

  task automatic vsync_fall(input int n);
    for (int i = 0; i < n; i++) begin
      vsync_in = 1'b0;
      @(posedge clk_25mhz); #1;
      vsync_in = 1'b1;
      @(posedge clk_25mhz); #1;
    end
  endtask

  // Count clock edges until busy drops; the edge where it drops is included.
  task automatic wait_idle(output int n);
    n = 0;
    do begin
      @(posedge clk_25mhz); #1;
      n++;
    end while (cpu_if.busy && n < 3000);
    if (cpu_if.busy) $display("FAIL busy_timeout: busy still high after %0d clocks", n);
  endtask

  // Walk all cells once and count those whose glyph code is not a space.
  task automatic scan_cells(output int bad);
    bad = 0;
    for (int c = 0; c < 2400; c++) begin
      x  = 10'((c % 80) * 8);
      y  = 10'((c / 80) * 16 + 3);
      de = 1'b1;
      @(posedge clk_25mhz); #1;
      if (font_addr[10:4] != 7'h20) bad++;
    end
    de = 1'b0;
  endtask

  // Render a w x h pixel window in a single cell and check rgb 3 clocks later.
  task automatic run_pix(input string tag, input int x0, input int y0, input int w,
                         input int h, input logic [7:0] cv, input bit cur_vis);
    exp_q.delete();
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        x  = 10'(x0 + c);
        y  = 10'(y0 + r);
        de = 1'b1;
        exp_q.push_back(exp_pix(cv, x, y, cur_vis));
        @(posedge clk_25mhz); #1;
        if (exp_q.size() == 3) check(tag, rgb, exp_q.pop_front());
      end
    end
    de = 1'b0;
    while (exp_q.size() > 0) begin
      @(posedge clk_25mhz); #1;
      check(tag, rgb, exp_q.pop_front());
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rgb"},   rgb, 8'h00);
    check({tag, "_hsync"}, hsync_out, 1'b1);
    check({tag, "_vsync"}, vsync_out, 1'b1);
    check({tag, "_busy"},  cpu_if.busy, 1'b1);
    check({tag, "_state"}, fsm_state, 1'b1);
  endtask

  // ---------------------------------------------------------------- main
  int n, m, bad;
  logic [15:0] hs_pat, vs_pat;

  initial begin
    rst_n = 1'b0;
    x = '0; y = '0; de = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1;
    cpu_if.wr_en = 1'b0; cpu_if.wr_addr = '0; cpu_if.wr_data = '0;
    cpu_if.cur_we = 1'b0; cpu_if.cur_addr = '0; cpu_if.clr_req = 1'b0;

    // 1: reset values, power-on sweep length, blank buffer
    repeat (3) @(posedge clk_25mhz);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
    wait_idle(n);
    check("reset_sweep_len", n, 2400);
    check("idle_state", fsm_state, 1'b0);
    scan_cells(bad);
    check("reset_cells_blank", bad, 0);
    run_pix("blank_pix", 160, 16, 8, 2, 8'h20, 1'b0);

    // 2: glyph row timing on cell 0; cursor sits at cell 0 with phase on
    cpu_write(12'd0, 8'h41);
    run_pix("cell0_row0", 0, 0, 8, 1, 8'h41, 1'b0);
    run_pix("cell0_cursor", 0, 13, 8, 3, 8'h41, 1'b1);

    // 3: inverse video in the last cell; an out-of-range write is dropped
    cpu_write(12'd2399, 8'hC1);
    cpu_write(12'd2400, 8'h41);
    check("oob_write_busy", cpu_if.busy, 1'b0);
    run_pix("cell2399_inv", 632, 464, 8, 16, 8'hC1, 1'b0);

    // 4: cursor at cell 81 blinks with a 30-frame half period
    cpu_if.cur_we = 1'b1; cpu_if.cur_addr = 12'd81;
    @(posedge clk_25mhz); #1;
    cpu_if.cur_we = 1'b0;
    run_pix("cur81_on0", 8, 29, 8, 3, 8'h20, 1'b1);
    run_pix("cell0_nocur", 0, 14, 8, 2, 8'h41, 1'b0);
    vsync_fall(29);
    run_pix("cur81_on29", 8, 30, 8, 2, 8'h20, 1'b1);
    vsync_fall(1);
    run_pix("cur81_off30", 8, 30, 8, 2, 8'h20, 1'b0);
    vsync_fall(29);
    run_pix("cur81_off59", 8, 30, 8, 2, 8'h20, 1'b0);
    vsync_fall(1);
    run_pix("cur81_on60", 8, 30, 8, 2, 8'h20, 1'b1);

    // 6: sync delay and blanking with de=0
    hs_pat = 16'b1011_0011_1100_0101;
    vs_pat = 16'b1110_0111_0011_1011;
    sync_q.delete();
    de = 1'b0;
    for (int i = 0; i < 16; i++) begin
      hsync_in = hs_pat[i];
      vsync_in = vs_pat[i];
      sync_q.push_back({hs_pat[i], vs_pat[i]});
      @(posedge clk_25mhz); #1;
      if (sync_q.size() == 3) begin
        check("sync_delay", {hsync_out, vsync_out}, sync_q.pop_front());
        check("blank_rgb", rgb, 8'h00);
      end
    end
    hsync_in = 1'b1; vsync_in = 1'b1;
    while (sync_q.size() > 0) begin
      @(posedge clk_25mhz); #1;
      check("sync_delay", {hsync_out, vsync_out}, sync_q.pop_front());
    end

    // 5: clear wins over a same-cycle write; requests while busy are ignored
    cpu_if.clr_req = 1'b1;
    cpu_if.wr_en = 1'b1; cpu_if.wr_addr = 12'd7; cpu_if.wr_data = 8'h41;
    @(posedge clk_25mhz); #1;
    cpu_if.clr_req = 1'b0; cpu_if.wr_en = 1'b0;
    check("clr_busy_rise", cpu_if.busy, 1'b1);
    n = 0;
    repeat (10) begin
      @(posedge clk_25mhz); #1;
      n++;
    end
    cpu_if.clr_req = 1'b1;
    cpu_if.wr_en = 1'b1; cpu_if.wr_addr = 12'd5; cpu_if.wr_data = 8'h41;
    @(posedge clk_25mhz); #1;
    n++;
    cpu_if.clr_req = 1'b0; cpu_if.wr_en = 1'b0;
    wait_idle(m);
    check("clr_sweep_len", n + m, 2400);
    scan_cells(bad);
    check("clr_cells_blank", bad, 0);
    run_pix("cell2399_cleared", 632, 464, 8, 2, 8'h20, 1'b0);

    // Reset in the middle of a sweep restarts it from cell 0
    cpu_if.clr_req = 1'b1;
    @(posedge clk_25mhz); #1;
    cpu_if.clr_req = 1'b0;
    repeat (100) @(posedge clk_25mhz);
    #5;
    rst_n = 1'b0;
    #5;
    check_reset_values("midsweep_reset");
    @(posedge clk_25mhz); #1;
    rst_n = 1'b1;
    wait_idle(n);
    check("midsweep_sweep_len", n, 2400);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
